// File: rtl/jstk_spi_responder_pkg.sv
// Shared definitions for the PmodJSTK joystick SPI protocol.
//
// Contents:
//   JSTK_FRAME_BITS   bits in one joystick transaction (5 bytes)
//   JSTK_CMD_PREFIX   upper six bits of a valid LED command byte
//   JSTK_BYTE_*       byte positions inside the frame, byte 0 goes out first
//   jstkState_e       responder FSM states
//   jstkPackFrame()   builds the 40-bit reply frame from {x, y, buttons}. The
//                     master-side unpacker uses the same function, so both ends
//                     agree on the byte layout.
package jstk_spi_responder_pkg;

    localparam int         JSTK_FRAME_BITS = 40;
    localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

    localparam int JSTK_BYTE_XLO = 0;
    localparam int JSTK_BYTE_XHI = 1;
    localparam int JSTK_BYTE_YLO = 2;
    localparam int JSTK_BYTE_YHI = 3;
    localparam int JSTK_BYTE_BTN = 4;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } jstkState_e;

    // Bit index of the MSB of byte 'idx'. The frame is sent MSB first, so
    // byte 0 sits in the top eight bits.
    function automatic int jstkByteMsb(input int idx);
        return JSTK_FRAME_BITS - 1 - 8 * idx;
    endfunction

    // The joystick reports 10-bit positions as a low byte followed by a byte
    // that holds only the top two bits.
    function automatic logic [JSTK_FRAME_BITS-1:0] jstkPackFrame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        logic [JSTK_FRAME_BITS-1:0] frame;
        frame = '0;
        frame[jstkByteMsb(JSTK_BYTE_XLO) -: 8] = x[7:0];
        frame[jstkByteMsb(JSTK_BYTE_XHI) -: 8] = {6'b000000, x[9:8]};
        frame[jstkByteMsb(JSTK_BYTE_YLO) -: 8] = y[7:0];
        frame[jstkByteMsb(JSTK_BYTE_YHI) -: 8] = {6'b000000, y[9:8]};
        frame[jstkByteMsb(JSTK_BYTE_BTN) -: 8] = {5'b00000, btn};
        return frame;
    endfunction

endpackage

// File: rtl/jstk_spi_responder_in_sync.sv
// spi_in_sync: multi-stage synchronizer with an edge detector, used for each
// asynchronous SPI pin coming into the system clock domain.
//
// Ports:
//   clk      system clock
//   clr_n    asynchronous active-low reset
//   din_i    raw asynchronous input pin
//   level_o  synchronized level
//   rise_o   one-cycle pulse on a synchronized 0->1 transition
//   fall_o   one-cycle pulse on a synchronized 1->0 transition
//
// STAGES must be at least 2.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // The synchronizer chain resets to 0, so after reset SS reads low until
    // its real level has propagated. The responder waits for SS high before
    // it accepts a frame.
    // prev_q holds the previous synchronized level and is used for edge
    // detection.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level_o = chain_q[STAGES-1];
    assign rise_o  = chain_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: emulates a PmodJSTK joystick as an SPI mode-0 slave.
// It returns X/Y/button data in the 5-byte joystick frame and decodes the
// master's LED command byte. SS, SCLK and MOSI are oversampled in the clk
// domain, so clk must run at 8x SCLK or faster.
//
// Ports:
//   clk         system clock
//   clr_n       asynchronous active-low reset
//   SS          slave select from the master, active low
//   SCLK        SPI clock from the master (mode 0)
//   MOSI        master-out data
//   MISO        slave-out data, driven to 0 outside a frame
//   x_pos       10-bit X value to report
//   y_pos       10-bit Y value to report
//   buttons     {btn2, btn1, stick_press}
//   led         LED bits from the last valid command byte
//   frame_done  one-cycle pulse when a frame of exactly FRAME_BITS bits ends
//   frame_err   one-cycle pulse when a frame of any other length ends
module jstk_spi_responder
    import jstk_spi_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 40
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [5:0] FrameCount = 6'(FRAME_BITS);
    localparam logic [5:0] CountMax   = 6'h3F;

    logic ssLevel, ssRise, ssFall;
    logic sclkLevel, sclkRise, sclkFall;
    logic mosiLevel, mosiRise, mosiFall;
    logic unusedSyncBits;

    jstkState_e                 state_q, state_d;
    logic [JSTK_FRAME_BITS-1:0] txShift_q, txShift_d;
    logic [JSTK_FRAME_BITS-1:0] rxShift_q, rxShift_d;
    logic [5:0]                 bitCount_q, bitCount_d;
    logic                       miso_q, miso_d;
    logic [1:0]                 led_q, led_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    spi_in_sync #(.STAGES(SYNC_STAGES)) uSyncSs (
        .clk     (clk),
        .clr_n   (clr_n),
        .din_i   (SS),
        .level_o (ssLevel),
        .rise_o  (ssRise),
        .fall_o  (ssFall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) uSyncSclk (
        .clk     (clk),
        .clr_n   (clr_n),
        .din_i   (SCLK),
        .level_o (sclkLevel),
        .rise_o  (sclkRise),
        .fall_o  (sclkFall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) uSyncMosi (
        .clk     (clk),
        .clr_n   (clr_n),
        .din_i   (MOSI),
        .level_o (mosiLevel),
        .rise_o  (mosiRise),
        .fall_o  (mosiFall)
    );

    // The SCLK level and the MOSI edges are not needed. The SPI logic uses
    // only SCLK edges and the sampled MOSI level.
    assign unusedSyncBits = ^{sclkLevel, mosiRise, mosiFall};

    // State register for the FSM, the shift registers, the bit counter and
    // all registered outputs. A reset mid-frame drops everything and the FSM
    // waits for SS to go high again.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= WAIT_IDLE;
            txShift_q  <= '0;
            rxShift_q  <= '0;
            bitCount_q <= '0;
            miso_q     <= 1'b0;
            led_q      <= 2'b00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            txShift_q  <= txShift_d;
            rxShift_q  <= rxShift_d;
            bitCount_q <= bitCount_d;
            miso_q     <= miso_d;
            led_q      <= led_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic for the frame FSM.
    // In ACTIVE, ss_rise is checked first, so an SCLK edge in the same cycle
    // is dropped. An ss_fall in IDLE only starts the frame, so an SCLK rise
    // in the same cycle is ignored.
    // The reply data is copied when the frame starts, so later changes to
    // x_pos/y_pos/buttons do not affect the current frame.
    // A falling edge before the first rise is ignored. Without this, bit 39
    // would be lost when SCLK idles high.
    always_comb begin
        state_d    = state_q;
        txShift_d  = txShift_q;
        rxShift_d  = rxShift_q;
        bitCount_d = bitCount_q;
        miso_d     = miso_q;
        led_d      = led_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                miso_d = 1'b0;
                if (ssLevel) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                miso_d = 1'b0;
                if (ssFall) begin
                    txShift_d  = jstkPackFrame(x_pos, y_pos, buttons);
                    rxShift_d  = '0;
                    bitCount_d = '0;
                    miso_d     = txShift_d[JSTK_FRAME_BITS-1];
                    state_d    = ACTIVE;
                end
            end

            ACTIVE: begin
                if (ssRise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    if (bitCount_q == FrameCount) begin
                        done_d = 1'b1;
                        if (rxShift_q[JSTK_FRAME_BITS-1 -: 6] == JSTK_CMD_PREFIX) begin
                            led_d = rxShift_q[JSTK_FRAME_BITS-7 -: 2];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclkRise) begin
                    rxShift_d = {rxShift_q[JSTK_FRAME_BITS-2:0], mosiLevel};
                    if (bitCount_q != CountMax) begin
                        bitCount_d = bitCount_q + 6'd1;
                    end
                end else if (sclkFall && (bitCount_q != 6'd0)) begin
                    txShift_d = {txShift_q[JSTK_FRAME_BITS-2:0], 1'b0};
                    miso_d    = txShift_d[JSTK_FRAME_BITS-1];
                end
            end

            default: begin
                state_d = WAIT_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    assign MISO       = miso_q;
    assign led        = led_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder. It acts as the SPI master with a
// fixed table of frames, hand-written corner sequences and randomized frames.
// The expected results come from a behavioural joystick model.
module tb_jstk_spi_responder;

   // SCLK half period in clk cycles. This gives 16x oversampling, which meets
   // the 8x minimum.
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       SS = 1'b1;
   logic       SCLK = 1'b0;
   logic       MOSI = 1'b0;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic [2:0] buttons = '0;
   logic       MISO;
   logic [1:0] led;
   logic       frame_done;
   logic       frame_err;

   int compared = 0;
   int mismatched = 0;
   int doneCount = 0;
   int errCount = 0;
   logic [1:0] modelLed = 2'b00;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [2:0]  btn;
      logic [63:0] mosi;
      int          nBits;
      logic [63:0] expMiso;
      int          expDone;
      int          expErr;
      logic [1:0]  expLed;
   } vector_t;

   vector_t vectors [6];

   jstk_spi_responder #(
      .SYNC_STAGES (2),
      .FRAME_BITS  (40)
   ) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .SS         (SS),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .buttons    (buttons),
      .led        (led),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   // 20-unit period system clock
   always #10 clk = ~clk;

   // Count the completion pulses on the falling edge, away from the edge
   // that updates them
   always @(negedge clk) begin
      if (frame_done) doneCount++;
      if (frame_err) errCount++;
   end

   // Stop a hung run before the cycle budget is exceeded
   initial begin
      #1_800_000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Joystick reply frame: the 10-bit positions are split into a low byte and
   // a high byte, followed by the button byte
   function automatic logic [39:0] modelFrame(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] btn);
      logic [39:0] f;
      f = (40'(x % 256) << 32) | (40'(x / 256) << 24) |
          (40'(y % 256) << 16) | (40'(y / 256) << 8) | 40'(btn);
      return f;
   endfunction

   // What the master sees on MISO for nBits rising edges. Bits past the end
   // of the frame are 0.
   function automatic logic [63:0] modelMiso(input logic [39:0] frame, input int nBits);
      logic [63:0] r;
      logic        b;
      r = '0;
      for (int i = 0; i < nBits; i++) begin
         b = (i < 40) ? frame[39 - i] : 1'b0;
         r = {r[62:0], b};
      end
      return r;
   endfunction

   // The LED command applies only in a full-length frame whose first byte
   // is 100000xx
   function automatic logic [1:0] modelLedAfter(input logic [1:0] oldLed,
                                                input logic [63:0] mosi, input int nBits);
      if (nBits == 40 && mosi[39:34] == 6'b100000) return mosi[33:32];
      return oldLed;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One master transaction. Bit changeBit swaps x_pos mid-frame. Bit
   // resetBit pulses clr_n with SS still low. gap is the number of SS-high
   // cycles after the frame. Pass -1 to skip the change or the reset.
   task automatic applyStimulus(input logic [63:0] mosiBits, input int nBits,
                                input int changeBit, input logic [9:0] newX,
                                input int resetBit, input int gap,
                                output logic [63:0] rcv);
      rcv = '0;
      @(negedge clk);
      SS = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nBits; i++) begin
         if (i == changeBit) x_pos = newX;
         if (i == resetBit) begin
            clr_n = 1'b0;
            @(negedge clk);
            checkOutput("reset_mid_miso", 64'(MISO), 64'd0);
            checkOutput("reset_mid_led", 64'(led), 64'd0);
            checkOutput("reset_mid_done", 64'(frame_done), 64'd0);
            repeat (2) @(negedge clk);
            clr_n = 1'b1;
            @(negedge clk);
         end
         MOSI = mosiBits[nBits - 1 - i];
         repeat (HALF) @(negedge clk);
         SCLK = 1'b1;
         rcv = {rcv[62:0], MISO};
         repeat (HALF) @(negedge clk);
         SCLK = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      SS = 1'b1;
      MOSI = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic checkFrameResult(input logic [63:0] rcv, input logic [63:0] expMiso,
                                   input int d0, input int e0, input int expDone,
                                   input int expErr, input logic [1:0] expLed);
      checkOutput("miso_data", rcv, expMiso);
      checkOutput("done_pulses", 64'(doneCount - d0), 64'(expDone));
      checkOutput("err_pulses", 64'(errCount - e0), 64'(expErr));
      checkOutput("led", 64'(led), 64'(expLed));
      checkOutput("miso_idle", 64'(MISO), 64'd0);
   endtask

   initial begin
      logic [63:0] rcv, rcv2, m;
      logic [7:0]  cmd;
      int          d0, e0, n;

      vectors[0] = '{10'h2A5, 10'h13C, 3'b101, 64'h81_00000000, 40,
                     64'hA5_02_3C_01_05, 1, 0, 2'b01};
      vectors[1] = '{10'h2A5, 10'h13C, 3'b101, 64'h8200, 16,
                     64'hA502, 0, 1, 2'b01};
      vectors[2] = '{10'h0FF, 10'h300, 3'b010, 64'h43_00000000, 40,
                     64'hFF_00_00_03_02, 1, 0, 2'b01};
      vectors[3] = '{10'h3FF, 10'h001, 3'b111, 64'h83_00000000, 40,
                     64'hFF_03_01_00_07, 1, 0, 2'b11};
      vectors[4] = '{10'h155, 10'h2AA, 3'b000, 64'h800_0000_0000, 44,
                     64'h55_01_AA_02_00_0, 0, 1, 2'b11};
      vectors[5] = '{10'h000, 10'h000, 3'b000, 64'h82_00000000, 40,
                     64'h0, 1, 0, 2'b10};

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("reset_miso", 64'(MISO), 64'd0);
      checkOutput("reset_led", 64'(led), 64'd0);
      checkOutput("reset_done", 64'(frame_done), 64'd0);
      checkOutput("reset_err", 64'(frame_err), 64'd0);
      clr_n = 1'b1;
      repeat (6) @(negedge clk);

      // Fixed frame table
      for (int v = 0; v < 6; v++) begin
         x_pos = vectors[v].x;
         y_pos = vectors[v].y;
         buttons = vectors[v].btn;
         repeat (2) @(negedge clk);
         d0 = doneCount;
         e0 = errCount;
         applyStimulus(vectors[v].mosi, vectors[v].nBits, -1, 10'h0, -1, 6, rcv);
         checkFrameResult(rcv, vectors[v].expMiso, d0, e0, vectors[v].expDone,
                          vectors[v].expErr, vectors[v].expLed);
         modelLed = vectors[v].expLed;
      end

      // Latency: MISO follows SS fall and SCLK fall after three clocks, and
      // frame_err follows SS rise after three clocks
      x_pos = 10'h2A5;
      y_pos = 10'h13C;
      buttons = 3'b101;
      @(negedge clk);
      SS = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("ss_fall_miso_early", 64'(MISO), 64'd0);
      @(negedge clk);
      checkOutput("ss_fall_miso", 64'(MISO), 64'd1);
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("sclk_fall_miso_early", 64'(MISO), 64'd1);
      @(negedge clk);
      checkOutput("sclk_fall_miso", 64'(MISO), 64'd0);
      repeat (HALF) @(negedge clk);
      SS = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("ss_rise_err_early", 64'(frame_err), 64'd0);
      @(negedge clk);
      checkOutput("ss_rise_err", 64'(frame_err), 64'd1);
      repeat (4) @(negedge clk);
      checkOutput("one_bit_led", 64'(led), 64'(modelLed));

      // Snapshot: X changes after byte 0 has gone out
      x_pos = 10'h000;
      y_pos = 10'h155;
      buttons = 3'b011;
      repeat (2) @(negedge clk);
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(64'h00_00000000, 40, 10, 10'h3FF, -1, 6, rcv);
      checkFrameResult(rcv, 64'h00_00_55_01_03, d0, e0, 1, 0, modelLed);

      // Reset mid-frame at bit 20, then a normal frame
      x_pos = 10'h2A5;
      y_pos = 10'h13C;
      buttons = 3'b101;
      repeat (2) @(negedge clk);
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(64'h81_00000000, 40, -1, 10'h0, 20, 6, rcv);
      checkOutput("reset_frame_done", 64'(doneCount - d0), 64'd0);
      checkOutput("reset_frame_err", 64'(errCount - e0), 64'd0);
      checkOutput("reset_frame_led", 64'(led), 64'd0);
      modelLed = 2'b00;
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(64'h81_00000000, 40, -1, 10'h0, -1, 6, rcv);
      modelLed = modelLedAfter(modelLed, 64'h81_00000000, 40);
      checkFrameResult(rcv, modelMiso(modelFrame(x_pos, y_pos, buttons), 40),
                       d0, e0, 1, 0, modelLed);

      // Back-to-back frames with a two-cycle SS-high gap
      x_pos = 10'h1AB;
      y_pos = 10'h0F0;
      buttons = 3'b110;
      repeat (2) @(negedge clk);
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(64'h82_00000000, 40, -1, 10'h0, -1, 1, rcv);
      applyStimulus(64'h80_00000000, 40, -1, 10'h0, -1, 6, rcv2);
      checkOutput("b2b_first_data", rcv, modelMiso(modelFrame(10'h1AB, 10'h0F0, 3'b110), 40));
      modelLed = modelLedAfter(modelLedAfter(modelLed, 64'h82_00000000, 40),
                               64'h80_00000000, 40);
      checkFrameResult(rcv2, modelMiso(modelFrame(10'h1AB, 10'h0F0, 3'b110), 40),
                       d0, e0, 2, 0, modelLed);

      // Randomized frames checked against the model
      for (int k = 0; k < 10; k++) begin
         x_pos = 10'($urandom);
         y_pos = 10'($urandom);
         buttons = 3'($urandom);
         if ($urandom_range(0, 1) == 1) cmd = {6'b100000, 2'($urandom)};
         else cmd = 8'($urandom);
         if ($urandom_range(0, 1) == 1) n = 40;
         else n = $urandom_range(8, 48);
         m = {cmd, 32'($urandom), 24'h0} >> (64 - n);
         repeat (2) @(negedge clk);
         d0 = doneCount;
         e0 = errCount;
         applyStimulus(m, n, -1, 10'h0, -1, 6, rcv);
         modelLed = modelLedAfter(modelLed, m, n);
         checkFrameResult(rcv, modelMiso(modelFrame(x_pos, y_pos, buttons), n),
                          d0, e0, (n == 40) ? 1 : 0, (n == 40) ? 0 : 1, modelLed);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
